keypad_entry: RTL
=================

# keypad_entry

Scans a 4x4 matrix keypad and assembles a 4-digit BCD value from pressed digit keys. It is the input-side counterpart of the multiplexed 7-segment display path: it drives row strobes and reads column returns, where the display drives digit strobes and segment data. The block debounces key contacts and reports each accepted key as a one-cycle event. Its BCD output feeds the display driver directly.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row is held low; minimum 4.
- `DEBOUNCE_SCANS`, default 8: consecutive identical samples required to accept a press or a release; minimum 2.
- `CLK` in 1: single system clock.
- `RESET_N` in 1: reset, asynchronous assert, active-low.
- `ROW` out 4: row strobes, active-low, exactly one row low at any time.
- `COL` in 4: column returns, active-low, externally pulled up, asynchronous to `CLK`.
- `key_valid` out 1: one-cycle pulse per accepted key press.
- `key_code` out 4: code of the last accepted key. Valid with `key_valid` and held until the next accepted key.
- `digits` out 16: BCD entry register. `[15:12]` holds thousands and `[3:0]` holds units.

## Operation
- Key map by row r (0..3) and column c (0..3):
  - r0 = 1,2,3,A
  - r1 = 4,5,6,B
  - r2 = 7,8,9,C
  - r3 = \*,0,#,D
- Key codes: digits map to their value; A=0xA, B=0xB, C=0xC, D=0xD, \*=0xE, #=0xF.
- `COL` passes through a 2-flop synchronizer. Columns are sampled on the last cycle of each row period.
- FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- **SCAN:** rows rotate 0→1→2→3→0, one per `SCAN_DIV` cycles.
  - A sample with exactly one column low latches the row and column, then goes to DEBOUNCE with the row frozen.
  - A sample with zero or two or more columns low continues scanning.
- **DEBOUNCE:** the row stays frozen and one sample is taken every `SCAN_DIV` cycles.
  - The same single column must be low for `DEBOUNCE_SCANS` consecutive samples, counting the initial sample. Then go to PRESSED.
  - Any differing sample, including a multi-column sample, returns to SCAN and resumes rotation from the next row.
- **PRESSED:** entered for one cycle. On the entry edge:
  - `key_valid` goes high and `key_code` is updated.
  - For codes 0–9: `digits <= {digits[11:0], code}`. The thousands digit is discarded.
  - For code 0xA: `digits <= 0` (clear).
  - For codes 0xB–0xF: `digits` is unchanged.
  - The next state is RELEASE.
- **RELEASE:** the row stays frozen.
  - All four columns must be high for `DEBOUNCE_SCANS` consecutive samples. Then return to SCAN.
  - Any low sample restarts the release count.
  - A second key pressed during RELEASE is ignored and never reported.
- Key auto-repeat is not supported.
- Reset values:
  - `ROW` = 4'b1110.
  - `key_valid` = 0, `key_code` = 0, `digits` = 0.
  - FSM in SCAN with all counters at 0.
  - Synchronizer flops reset to 4'b1111.

## Timing
- All outputs are registered.
- `key_valid` is high for exactly one `CLK` cycle. `key_code` and `digits` change on the same edge.
- Minimum press-to-`key_valid` latency, measured from the `COL` transition to the `key_valid` rising edge: 2 synchronizer cycles, plus wait for the sample point, plus (`DEBOUNCE_SCANS`−1)×`SCAN_DIV`, plus 1.
- Row changes take effect on the cycle after the period counter wraps. The first sample of a row is taken at least `SCAN_DIV`−1 cycles after the strobe, which allows the lines to settle.
- Asserting `RESET_N` mid-debounce or mid-release abandons the key with no `key_valid` and restores all reset values immediately. `digits` is cleared.
- The counter widths are log2-sized from the parameters.

## Structure
- Shared package `keypad_pkg`:
  - FSM state enum.
  - Key code constants: `KEY_CLEAR` = 4'hA and `KEY_STAR`/`KEY_HASH`.
  - The row/column-to-code lookup function.
- Sub-module `keypad_matrix_scan` contains the synchronizer, row rotation, debounce FSM and code lookup. It outputs `key_valid` and `key_code`.
- `keypad_entry` instantiates that sub-module and contains only the BCD entry register.

## Test plan
Run with `SCAN_DIV`=4 and `DEBOUNCE_SCANS`=3.
- **Reset:** hold `RESET_N`=0 with `COL` toggling → `ROW`=1110, `key_valid`=0, `digits`=0x0000. After release, `ROW` cycles 1110, 1101, 1011, 0111, each held for 4 cycles.
- **Single digit:** model press of key 5 (row 1, column 1) for 40 cycles, then release → exactly one `key_valid` pulse with `key_code`=5, and `digits`=0x0005.
- **Entry and overflow:** press 1,2,3,4,7 in sequence → `digits` reads 0x0001, 0x0012, 0x0123, 0x1234, 0x2347. Then press A → `digits`=0x0000 and `key_code`=0xA. Then press # → `digits` unchanged and `key_code`=0xF.
- **Bounce rejection:** column toggles every 3 cycles for 30 cycles, then settles low → exactly one `key_valid`. A 2-sample glitch produces no `key_valid`.
- **Multi-key and held key:** two columns low on the same row → no `key_valid`. Hold key 9 for 500 cycles → one pulse only. Press key 0 while 9 is still held, then release both → no pulse for 0.
- **Reset mid-operation:** assert `RESET_N` during DEBOUNCE of key 8 with `digits`=0x0042 → no `key_valid`, `digits`=0x0000 and `ROW`=1110 immediately.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, key codes and the matrix position to key code lookup.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_STAR  = 4'hE;
  localparam logic [3:0] KEY_HASH  = 4'hF;

  // Row r / column c to key code; digits map to their own value.
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = KEY_CLEAR;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Active-low strobe pattern for one row index.
  function automatic logic [3:0] row_strobe(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad pins and entry results bundled between the block and its environment.
interface keypad_entry_if;
  logic [3:0]  ROW;
  logic [3:0]  COL;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;

  modport master (input ROW, key_valid, key_code, digits, output COL);
  modport slave  (output ROW, key_valid, key_code, digits, input COL);
endinterface

// File: rtl/keypad_matrix_scan.sv
// Row scanning, column synchronizer, press/release debounce and key lookup.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SCAN     | rotate rows, look for exactly one low column
// DEBOUNCE | row frozen, same single column must repeat on every sample
// PRESSED  | one cycle; key accepted, key_valid high
// RELEASE  | row frozen, wait for all columns high on consecutive samples
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_col,
  output logic [3:0] o_row,
  output logic       o_key_valid,
  output logic [3:0] o_key_code,
  output logic       o_accept,
  output logic [3:0] o_accept_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_SCANS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SCANS - 1);

  logic [3:0]       r_col_s1, r_col_s2;
  logic [DIV_W-1:0] r_div;
  kp_state_e        r_state, w_state_nxt;
  logic [1:0]       r_row_idx, w_row_idx_nxt;
  logic [1:0]       r_col_idx, w_col_idx_nxt;
  logic [DEB_W-1:0] r_deb_cnt, w_deb_nxt;
  logic [3:0]       r_row;
  logic             r_key_valid;
  logic [3:0]       r_key_code;
  logic             w_sample, w_single, w_accept;
  logic [3:0]       w_low;
  logic [1:0]       w_col_idx;

  // Two-flop synchronizer for the asynchronous column returns.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
    end else begin
      r_col_s1 <= i_col;
      r_col_s2 <= r_col_s1;
    end
  end

  // Row period counter; the sample point is the last cycle of each period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_div <= '0;
    else if (r_div == DIV_LAST) r_div <= '0;
    else r_div <= r_div + 1'b1;
  end

  assign w_sample = (r_div == DIV_LAST);
  assign w_low    = ~r_col_s2;
  assign w_single = (w_low != 4'h0) && ((w_low & (w_low - 4'h1)) == 4'h0);

  // Index of the single low column (meaningful only when w_single).
  always_comb begin
    w_col_idx = 2'd0;
    case (w_low)
      4'b0010: w_col_idx = 2'd1;
      4'b0100: w_col_idx = 2'd2;
      4'b1000: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  // Next-state, row/column latch and debounce counter decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_idx_nxt = r_row_idx;
    w_col_idx_nxt = r_col_idx;
    w_deb_nxt     = r_deb_cnt;
    w_accept      = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (w_sample) begin
          if (w_single) begin
            w_col_idx_nxt = w_col_idx;
            w_deb_nxt     = DEB_W'(1);
            w_state_nxt   = ST_DEBOUNCE;
          end else begin
            w_row_idx_nxt = r_row_idx + 2'd1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (w_sample) begin
          if (w_single && (w_col_idx == r_col_idx)) begin
            if (r_deb_cnt == DEB_LAST) begin
              w_accept    = 1'b1;
              w_deb_nxt   = '0;
              w_state_nxt = ST_PRESSED;
            end else begin
              w_deb_nxt = r_deb_cnt + 1'b1;
            end
          end else begin
            w_deb_nxt     = '0;
            w_row_idx_nxt = r_row_idx + 2'd1;
            w_state_nxt   = ST_SCAN;
          end
        end
      end
      ST_PRESSED: begin
        w_deb_nxt   = '0;
        w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (w_sample) begin
          if (r_col_s2 == 4'hF) begin
            if (r_deb_cnt == DEB_LAST) begin
              w_deb_nxt     = '0;
              w_row_idx_nxt = r_row_idx + 2'd1;
              w_state_nxt   = ST_SCAN;
            end else begin
              w_deb_nxt = r_deb_cnt + 1'b1;
            end
          end else begin
            w_deb_nxt = '0;
          end
        end
      end
      default: begin
        w_deb_nxt   = '0;
        w_state_nxt = ST_SCAN;
      end
    endcase
  end

  // State register plus registered row strobes and key report.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_SCAN;
      r_row_idx   <= 2'd0;
      r_col_idx   <= 2'd0;
      r_deb_cnt   <= '0;
      r_row       <= 4'b1110;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_col_idx   <= w_col_idx_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_row       <= row_strobe(w_row_idx_nxt);
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= o_accept_code;
    end
  end

  assign o_accept_code = key_lookup(r_row_idx, r_col_idx);
  assign o_accept      = w_accept;
  assign o_row         = r_row;
  assign o_key_valid   = r_key_valid;
  assign o_key_code    = r_key_code;

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry top: scanner plus the 4-digit BCD entry register.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input logic           CLK,
  input logic           RESET_N,
  keypad_entry_if.slave bus
);

  logic        w_accept;
  logic [3:0]  w_accept_code;
  logic [15:0] r_digits;

  keypad_matrix_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scan (
    .i_clk        (CLK),
    .i_rst_n      (RESET_N),
    .i_col        (bus.COL),
    .o_row        (bus.ROW),
    .o_key_valid  (bus.key_valid),
    .o_key_code   (bus.key_code),
    .o_accept     (w_accept),
    .o_accept_code(w_accept_code)
  );

  // Digits shift in at the units end; clear wipes the entry, other keys leave it.
  // Updated from the accept strobe so it changes on the same edge as key_valid.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_digits <= 16'h0000;
    end else if (w_accept) begin
      if (w_accept_code <= 4'h9) r_digits <= {r_digits[11:0], w_accept_code};
      else if (w_accept_code == KEY_CLEAR) r_digits <= 16'h0000;
    end
  end

  assign bus.digits = r_digits;

endmodule
